// File: rtl/fruit_spawn_scheduler.sv
// fruit_spawn_scheduler: frame-paced allocator of playfield object slots.
// Every SPAWN_PERIOD frames the lowest free slot is reserved, its launch
// configuration is offered on a valid/ready handshake, and the slot becomes
// active on acceptance. An active slot is freed when its motion engine
// reports out-of-bounds.
// Optional feature: define SPAWN_RANDOM_EN to take posx, dx, sprite and speed
// from a free-running 16-bit LFSR instead of the deterministic derivation.
module fruit_spawn_scheduler #(
  parameter int unsigned SLOTS         = 4,
  parameter int unsigned DEPTH_BIT     = 19,
  parameter int unsigned SPAWN_PERIOD  = 60,
  parameter int unsigned SPRITE_BASE   = 18000,
  parameter int unsigned SPRITE_STRIDE = 8000,
  parameter int unsigned T_BASE        = 50000000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     frame_tick,
  input  logic [SLOTS-1:0]         oob,
  input  logic                     spawn_ready,
  output logic                     spawn_valid,
  output logic [$clog2(SLOTS)-1:0] spawn_slot,
  output logic [9:0]               spawn_posx,
  output logic [8:0]               spawn_posy,
  output logic [31:0]              spawn_tx,
  output logic                     spawn_dx,
  output logic                     spawn_dy,
  output logic [DEPTH_BIT-1:0]     spawn_addr,
  output logic [SLOTS-1:0]         slot_en,
  output logic [3:0]               active_count
);

  localparam int unsigned SLOT_W    = $clog2(SLOTS);
  localparam int unsigned POSX_STEP = 640 / SLOTS;
  localparam logic [7:0]  CNT_LAST  = 8'(SPAWN_PERIOD - 1);
  localparam logic [8:0]  POSY_INIT = 9'd400;

  // Parameter sanity checks at elaboration
  if (SLOTS < 2 || SLOTS > 8) begin : g_bad_slots
    $error("SLOTS must be in 2..8");
  end
  if (SPAWN_PERIOD < 1 || SPAWN_PERIOD > 256) begin : g_bad_period
    $error("SPAWN_PERIOD must be in 1..256");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_PICK  = 2'd2,
    S_ISSUE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [1:0]           n_q, n_d;
  logic [SLOTS-1:0]     slot_en_q, slot_en_d;
  logic [SLOTS-1:0]     rsv_q, rsv_d;
  logic [3:0]           active_q, active_d;
  logic                 valid_q, valid_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [9:0]           posx_q, posx_d;
  logic [8:0]           posy_q, posy_d;
  logic [31:0]          tx_q, tx_d;
  logic                 dx_q, dx_d;
  logic                 dy_q, dy_d;
  logic [DEPTH_BIT-1:0] addr_q, addr_d;

  logic                 free_found;
  logic [SLOT_W-1:0]    free_idx;
  logic [9:0]           pick_posx;
  logic                 pick_dx;
  logic [1:0]           pick_sprite;
  logic [1:0]           pick_k;
  logic                 handshake;

  // Lowest-index slot that is neither active nor reserved
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!slot_en_q[i] && !rsv_q[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
  end

`ifdef SPAWN_RANDOM_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16/14/13/11, free-running every clock
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  // Randomised launch fields from the current LFSR value
  always_comb begin
    pick_posx   = {1'b0, lfsr_q[8:0]};
    pick_dx     = lfsr_q[9];
    pick_sprite = lfsr_q[11:10];
    pick_k      = lfsr_q[13:12];
  end
`else
  // Deterministic launch fields from the slot and the spawn index
  always_comb begin
    pick_posx   = 10'(32'(free_idx) * POSX_STEP);
    pick_dx     = n_q[0];
    pick_sprite = n_q;
    pick_k      = n_q;
  end
`endif

  // Next-state, slot bookkeeping and launch-field latch
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    rsv_d     = rsv_q;
    valid_d   = valid_q;
    slot_d    = slot_q;
    posx_d    = posx_q;
    posy_d    = posy_q;
    tx_d      = tx_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    addr_d    = addr_q;
    handshake = valid_q & spawn_ready;
    // out-of-bounds only affects slots that are actually active
    slot_en_d = slot_en_q & ~oob;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_PICK;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_PICK: begin
        if (free_found) begin
          slot_d          = free_idx;
          posx_d          = pick_posx;
          posy_d          = POSY_INIT;
          dx_d            = pick_dx;
          dy_d            = 1'b1;
          tx_d            = 32'(T_BASE >> (32'd5 + 32'(pick_k)));
          addr_d          = DEPTH_BIT'(SPRITE_BASE + 32'(pick_sprite) * SPRITE_STRIDE);
          rsv_d[free_idx] = 1'b1;
          valid_d         = 1'b1;
          state_d         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (handshake) begin
          slot_en_d[slot_q] = 1'b1;
          rsv_d[slot_q]     = 1'b0;
          n_d               = n_q + 2'd1;
          valid_d           = 1'b0;
          state_d           = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Population count of the next slot_en value
  always_comb begin
    active_d = '0;
    for (int i = 0; i < SLOTS; i++) begin
      active_d = active_d + 4'(slot_en_d[i]);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      slot_en_q <= '0;
      rsv_q     <= '0;
      active_q  <= '0;
      valid_q   <= 1'b0;
      slot_q    <= '0;
      posx_q    <= '0;
      posy_q    <= '0;
      tx_q      <= '0;
      dx_q      <= 1'b0;
      dy_q      <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      slot_en_q <= slot_en_d;
      rsv_q     <= rsv_d;
      active_q  <= active_d;
      valid_q   <= valid_d;
      slot_q    <= slot_d;
      posx_q    <= posx_d;
      posy_q    <= posy_d;
      tx_q      <= tx_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      addr_q    <= addr_d;
    end
  end

  assign spawn_valid  = valid_q;
  assign spawn_slot   = slot_q;
  assign spawn_posx   = posx_q;
  assign spawn_posy   = posy_q;
  assign spawn_tx     = tx_q;
  assign spawn_dx     = dx_q;
  assign spawn_dy     = dy_q;
  assign spawn_addr   = addr_q;
  assign slot_en      = slot_en_q;
  assign active_count = active_q;

endmodule
